// File: rtl/game_pkg.sv
// game_pkg: playfield geometry, tile codes and object snapshot types
// shared by the game engine and the frame tile scanner.
package game_pkg;

  localparam int COLS    = 20;
  localparam int ROWS    = 15;
  localparam int X_W     = 5;
  localparam int Y_W     = 4;
  localparam int T_W     = 3;
  localparam int N_ENEMY = 3;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;
  typedef logic [T_W-1:0] tile_t;

  localparam tile_t TILE_EMPTY  = 3'd0;
  localparam tile_t TILE_PLAYER = 3'd1;
  localparam tile_t TILE_ENEMY  = 3'd2;
  localparam tile_t TILE_BULLET = 3'd3;
  localparam tile_t TILE_FLASH  = 3'd4;

  typedef struct packed {
    x_t   x;
    y_t   y;
    logic active;
  } obj_t;

  typedef struct packed {
    obj_t                    player;
    obj_t                    bullet;
    obj_t [N_ENEMY-1:0]      enemy;
    logic                    flash;
  } snap_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  // Off-field objects never match: no modulo wrap onto the grid.
  function automatic logic at_cell(obj_t o, x_t x, y_t y);
    return o.active
      && (o.x < x_t'(COLS))
      && (o.y < y_t'(ROWS))
      && (o.x == x)
      && (o.y == y);
  endfunction

endpackage

// File: rtl/frame_tile_scanner_if.sv
// frame_tile_scanner_if: valid/ready tile stream from the scanner
// to the tile renderer or frame dumper.
interface frame_tile_scanner_if;

  logic           tile_valid;
  logic           tile_ready;
  game_pkg::x_t   tile_x;
  game_pkg::y_t   tile_y;
  game_pkg::tile_t tile_code;
  logic           tile_last;

  modport master (
    output tile_valid,
    output tile_x,
    output tile_y,
    output tile_code,
    output tile_last,
    input  tile_ready
  );

  modport slave (
    input  tile_valid,
    input  tile_x,
    input  tile_y,
    input  tile_code,
    input  tile_last,
    output tile_ready
  );

endinterface

// File: rtl/tile_classify.sv
// tile_classify: combinational priority encoder from a cell and the
// object snapshot to a tile code (player > enemy > bullet > flash).
module tile_classify
  import game_pkg::*;
(
  input  x_t    x,
  input  y_t    y,
  input  snap_t snap,
  output tile_t code
);

  logic enemy_hit;

  always_comb begin
    enemy_hit = 1'b0;
    for (int e = 0; e < N_ENEMY; e++) begin
      enemy_hit = enemy_hit | at_cell(snap.enemy[e], x, y);
    end
  end

  always_comb begin
    code = TILE_EMPTY;
    if (at_cell(snap.player, x, y)) begin
      code = TILE_PLAYER;
    end else if (enemy_hit) begin
      code = TILE_ENEMY;
    end else if (at_cell(snap.bullet, x, y)) begin
      code = TILE_BULLET;
    end else if (snap.flash && (y == '0)) begin
      code = TILE_FLASH;
    end
  end

endmodule

// File: rtl/frame_tile_scanner.sv
// frame_tile_scanner: snapshots game objects on frame_start and streams
// the playfield in raster order. Optional row-0 hit flash: HIT_FLASH_EN.
module frame_tile_scanner
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  x_t         player_x,
  input  y_t         player_y,
  input  x_t         bullet_x,
  input  y_t         bullet_y,
  input  logic       bullet_active,
  input  x_t         enemy0_x,
  input  y_t         enemy0_y,
  input  logic       enemy0_active,
  input  x_t         enemy1_x,
  input  y_t         enemy1_y,
  input  logic       enemy1_active,
  input  x_t         enemy2_x,
  input  y_t         enemy2_y,
  input  logic       enemy2_active,
  input  logic       hit,
  input  logic [7:0] score,
  frame_tile_scanner_if.master tile,
  output logic [7:0] frame_score,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_overrun
);

  scan_state_t state_q;
  scan_state_t state_d;
  x_t          x_q;
  y_t          y_q;
  snap_t       snap_q;
  snap_t       snap_in;
  logic [7:0]  score_q;
  logic        flash_in;
  logic        start;
  logic        scan;
  logic        hs;
  logic        at_end;
  tile_t       code;

  assign scan   = (state_q == S_SCAN);
  assign start  = frame_start && (state_q == S_IDLE);
  assign hs     = scan && tile.tile_ready;
  assign at_end = (x_q == x_t'(COLS-1))
               && (y_q == y_t'(ROWS-1));

`ifdef HIT_FLASH_EN
  logic hit_pending_q;

  // A hit in the snapshot cycle belongs to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_pending_q <= 1'b0;
    end else if (start) begin
      hit_pending_q <= hit;
    end else if (hit) begin
      hit_pending_q <= 1'b1;
    end
  end

  assign flash_in = hit_pending_q;
`else
  logic unused_hit;

  assign unused_hit = hit;
  assign flash_in   = 1'b0;
`endif

  always_comb begin
    snap_in          = '0;
    snap_in.player   = '{x: player_x, y: player_y, active: 1'b1};
    snap_in.bullet   = '{x: bullet_x, y: bullet_y, active: bullet_active};
    snap_in.enemy[0] = '{x: enemy0_x, y: enemy0_y, active: enemy0_active};
    snap_in.enemy[1] = '{x: enemy1_x, y: enemy1_y, active: enemy1_active};
    snap_in.enemy[2] = '{x: enemy2_x, y: enemy2_y, active: enemy2_active};
    snap_in.flash    = flash_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      snap_q  <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        snap_q  <= snap_in;
        score_q <= score;
        x_q     <= '0;
        y_q     <= '0;
      end else if (hs) begin
        if (at_end) begin
          x_q <= '0;
          y_q <= '0;
        end else if (x_q == x_t'(COLS-1)) begin
          x_q <= '0;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (hs && at_end) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  tile_classify u_classify (
    .x    (x_q),
    .y    (y_q),
    .snap (snap_q),
    .code (code)
  );

  assign tile.tile_valid = scan;
  assign tile.tile_x     = x_q;
  assign tile.tile_y     = y_q;
  assign tile.tile_code  = scan ? code : TILE_EMPTY;
  assign tile.tile_last  = scan && at_end;

  assign frame_score   = score_q;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = (state_q == S_DONE);
  assign frame_overrun = frame_start && busy;

endmodule

// File: tb/tb_frame_tile_scanner.sv
// tb_frame_tile_scanner: directed scenarios for the frame tile scanner
// with a reference tile map built from the driven object positions.
module tb_frame_tile_scanner;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       hit = 1'b0;
  logic [4:0] px = '0;
  logic [3:0] py = '0;
  logic [4:0] bx = '0;
  logic [3:0] by = '0;
  logic       ba = 1'b0;
  logic [4:0] ex [3];
  logic [3:0] ey [3];
  logic       ea [3];
  logic [7:0] score = '0;
  logic [7:0] frame_score;
  logic       busy;
  logic       frame_done;
  logic       frame_overrun;

  frame_tile_scanner_if tif ();

  always #5 clk = ~clk;

  frame_tile_scanner dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .player_x      (px),
    .player_y      (py),
    .bullet_x      (bx),
    .bullet_y      (by),
    .bullet_active (ba),
    .enemy0_x      (ex[0]),
    .enemy0_y      (ey[0]),
    .enemy0_active (ea[0]),
    .enemy1_x      (ex[1]),
    .enemy1_y      (ey[1]),
    .enemy1_active (ea[1]),
    .enemy2_x      (ex[2]),
    .enemy2_y      (ey[2]),
    .enemy2_active (ea[2]),
    .hit           (hit),
    .score         (score),
    .tile          (tif),
    .frame_score   (frame_score),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun)
  );

  int n_chk = 0;
  int n_fail = 0;

  int s_px, s_py, s_bx, s_by, s_ba, s_fl;
  int s_ex [3];
  int s_ey [3];
  int s_ea [3];

  int got_x [400];
  int got_y [400];
  int got_c [400];
  int got_l [400];
  int n_hs, done_cyc, n_done, n_ovr, n_stall_bad, last_cyc;

  function automatic int exp_code(int x, int y);
    if (x == s_px && y == s_py) return 1;
    for (int e = 0; e < 3; e++)
      if (s_ea[e] != 0 && x == s_ex[e] && y == s_ey[e]) return 2;
    if (s_ba != 0 && x == s_bx && y == s_by) return 3;
    if (s_fl != 0 && y == 0) return 4;
    return 0;
  endfunction

  task automatic set_basic();
    px = 5'd10; py = 4'd14;
    ex[0] = 5'd3; ey[0] = 4'd0; ea[0] = 1'b1;
    ex[1] = 5'd0; ey[1] = 4'd0; ea[1] = 1'b0;
    ex[2] = 5'd0; ey[2] = 4'd0; ea[2] = 1'b0;
    bx = 5'd10; by = 4'd13; ba = 1'b1;
    s_fl = 0;
  endtask

  task automatic pulse_start(input bit with_hit);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    hit = with_hit;
    s_px = px; s_py = py; s_bx = bx; s_by = by; s_ba = ba;
    for (int e = 0; e < 3; e++) begin
      s_ex[e] = ex[e]; s_ey[e] = ey[e]; s_ea[e] = ea[e];
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    hit = 1'b0;
  endtask

  // Records the handshaked stream; returns after frame_done or the budget.
  task automatic collect(input int mode, input int ovr_at, input int chg_at);
    int cyc;
    bit pv, ovr_done, chg_done, fin;
    int p_x, p_y, p_c, p_l;
    cyc = 1; pv = 0; ovr_done = 0; chg_done = 0; fin = 0;
    p_x = 0; p_y = 0; p_c = 0; p_l = 0;
    n_hs = 0; done_cyc = -1; n_done = 0; n_ovr = 0;
    n_stall_bad = 0; last_cyc = -1;
    tif.tile_ready = (mode == 0) || ($urandom_range(0, 3) == 0)
                  || (cyc % 4 == 0) || (cyc % 4 == 3);
    while (!fin && cyc <= 2000) begin
      @(negedge clk);
      if (pv) begin
        if (!tif.tile_valid || tif.tile_x != p_x || tif.tile_y != p_y
            || tif.tile_code != p_c || tif.tile_last != p_l)
          n_stall_bad++;
      end
      if (tif.tile_valid && tif.tile_ready) begin
        if (n_hs < 400) begin
          got_x[n_hs] = tif.tile_x;
          got_y[n_hs] = tif.tile_y;
          got_c[n_hs] = tif.tile_code;
          got_l[n_hs] = tif.tile_last;
        end
        if (tif.tile_last) last_cyc = cyc;
        n_hs++;
      end
      if (frame_overrun) n_ovr++;
      if (frame_done) begin
        n_done++;
        done_cyc = cyc;
        fin = 1;
      end
      p_x = tif.tile_x; p_y = tif.tile_y;
      p_c = tif.tile_code; p_l = tif.tile_last;
      pv = tif.tile_valid && !tif.tile_ready;
      if (!fin) begin
        @(posedge clk);
        #1;
        cyc++;
        frame_start = 1'b0;
        if (!ovr_done && ovr_at >= 0 && n_hs == ovr_at) begin
          frame_start = 1'b1;
          ovr_done = 1;
        end
        if (!chg_done && chg_at >= 0 && n_hs >= chg_at) begin
          ex[0] = 5'd15; ey[0] = 4'd10; ea[0] = 1'b1;
          chg_done = 1;
        end
        tif.tile_ready = (mode == 0) || ($urandom_range(0, 3) == 0)
                      || (cyc % 4 == 0) || (cyc % 4 == 3);
      end
    end
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if (tif.tile_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0
        || frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b ovr=%b, want all 0",
               tif.tile_valid, busy, frame_done, frame_overrun);
    end
    n_chk++;
    if (tif.tile_x !== 5'd0 || tif.tile_y !== 4'd0 || tif.tile_code !== 3'd0
        || tif.tile_last !== 1'b0 || frame_score !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_data: x=%0d y=%0d code=%0d last=%b score=%0d, want 0",
               tif.tile_x, tif.tile_y, tif.tile_code, tif.tile_last, frame_score);
    end
  endtask

  task automatic test_basic();
    set_basic();
    score = 8'hA5;
    pulse_start(1'b0);
    score = 8'h3C;
    collect(0, -1, -1);
    n_chk++;
    if (n_hs !== 300) begin
      n_fail++;
      $display("FAIL basic_count: got %0d tiles, want 300", n_hs);
    end
    for (int i = 0; i < n_hs && i < 300; i++) begin
      n_chk++;
      if (got_x[i] !== i % 20 || got_y[i] !== i / 20
          || got_c[i] !== exp_code(i % 20, i / 20) || got_l[i] !== (i == 299)) begin
        n_fail++;
        $display("FAIL basic_tile %0d: got (%0d,%0d) code %0d last %0d, want (%0d,%0d) code %0d",
                 i, got_x[i], got_y[i], got_c[i], got_l[i], i % 20, i / 20,
                 exp_code(i % 20, i / 20));
      end
    end
    n_chk++;
    if (last_cyc !== 300 || done_cyc !== 301 || n_done !== 1) begin
      n_fail++;
      $display("FAIL basic_latency: last at N+%0d done at N+%0d, want N+300 N+301",
               last_cyc, done_cyc);
    end
    n_chk++;
    if (frame_score !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_score: got %h, want a5", frame_score);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: busy=%b done=%b at N+302, want 0 0", busy, frame_done);
    end
  endtask

  task automatic test_back_to_back();
    set_basic();
    pulse_start(1'b0);
    collect(0, -1, -1);
    @(posedge clk);
    #1;
    frame_start = 1'b1;
    #1;
    n_chk++;
    if (frame_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %b at N+302, want 0", frame_overrun);
    end
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    n_chk++;
    if (tif.tile_valid !== 1'b1 || tif.tile_x !== 5'd0 || tif.tile_y !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_restart: valid=%b (%0d,%0d), want 1 (0,0)",
               tif.tile_valid, tif.tile_x, tif.tile_y);
    end
    collect(0, -1, -1);
    n_chk++;
    if (n_hs !== 300 || n_done !== 1) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d tiles %0d done, want 300 1", n_hs, n_done);
    end
  endtask

  task automatic test_priority();
    px = 5'd5; py = 4'd14;
    ex[0] = 5'd7; ey[0] = 4'd2; ea[0] = 1'b0;
    ex[1] = 5'd5; ey[1] = 4'd14; ea[1] = 1'b1;
    ex[2] = 5'd19; ey[2] = 4'd15; ea[2] = 1'b1;
    bx = 5'd20; by = 4'd3; ba = 1'b1;
    s_fl = 0;
    pulse_start(1'b0);
    collect(0, -1, -1);
    n_chk++;
    if (n_hs !== 300 || got_c[14*20+5] !== 1 || got_c[2*20+7] !== 0) begin
      n_fail++;
      $display("FAIL prio_cells: tiles %0d (5,14)=%0d (7,2)=%0d, want 300 1 0",
               n_hs, got_c[14*20+5], got_c[2*20+7]);
    end
    for (int i = 0; i < n_hs && i < 300; i++) begin
      n_chk++;
      if (got_c[i] !== exp_code(i % 20, i / 20)) begin
        n_fail++;
        $display("FAIL prio_tile %0d: got code %0d, want %0d",
                 i, got_c[i], exp_code(i % 20, i / 20));
      end
    end
  endtask

  task automatic test_stall();
    set_basic();
    pulse_start(1'b0);
    collect(1, -1, -1);
    n_chk++;
    if (n_hs !== 300 || n_stall_bad !== 0 || n_done !== 1) begin
      n_fail++;
      $display("FAIL stall_flow: tiles %0d unstable %0d done %0d, want 300 0 1",
               n_hs, n_stall_bad, n_done);
    end
    for (int i = 0; i < n_hs && i < 300; i++) begin
      n_chk++;
      if (got_x[i] !== i % 20 || got_y[i] !== i / 20
          || got_c[i] !== exp_code(i % 20, i / 20)) begin
        n_fail++;
        $display("FAIL stall_tile %0d: got (%0d,%0d) code %0d, want (%0d,%0d) code %0d",
                 i, got_x[i], got_y[i], got_c[i], i % 20, i / 20,
                 exp_code(i % 20, i / 20));
      end
    end
  endtask

  task automatic test_overrun();
    set_basic();
    pulse_start(1'b0);
    collect(0, 50, 60);
    n_chk++;
    if (n_ovr !== 1 || n_hs !== 300 || done_cyc !== 301) begin
      n_fail++;
      $display("FAIL ovr_flow: overrun %0d tiles %0d done N+%0d, want 1 300 N+301",
               n_ovr, n_hs, done_cyc);
    end
    for (int i = 0; i < n_hs && i < 300; i++) begin
      n_chk++;
      if (got_x[i] !== i % 20 || got_y[i] !== i / 20
          || got_c[i] !== exp_code(i % 20, i / 20)) begin
        n_fail++;
        $display("FAIL ovr_tile %0d: got (%0d,%0d) code %0d, want (%0d,%0d) code %0d",
                 i, got_x[i], got_y[i], got_c[i], i % 20, i / 20,
                 exp_code(i % 20, i / 20));
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad_done;
    set_basic();
    pulse_start(1'b0);
    tif.tile_ready = 1'b1;
    repeat (120) @(posedge clk);
    #1;
    n_chk++;
    if (tif.tile_valid !== 1'b1 || tif.tile_x !== 5'd0 || tif.tile_y !== 4'd6) begin
      n_fail++;
      $display("FAIL rst_pos: valid=%b (%0d,%0d), want 1 (0,6)",
               tif.tile_valid, tif.tile_x, tif.tile_y);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (tif.tile_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: valid=%b busy=%b, want 0 0", tif.tile_valid, busy);
    end
    bad_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done || tif.tile_valid) bad_done++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    if (frame_done || tif.tile_valid) bad_done++;
    n_chk++;
    if (bad_done !== 0) begin
      n_fail++;
      $display("FAIL rst_nodone: %0d cycles with done/valid, want 0", bad_done);
    end
    pulse_start(1'b0);
    collect(0, -1, -1);
    n_chk++;
    if (n_hs !== 300 || got_x[0] !== 0 || got_y[0] !== 0 || done_cyc !== 301) begin
      n_fail++;
      $display("FAIL rst_restart: tiles %0d first (%0d,%0d) done N+%0d, want 300 (0,0) N+301",
               n_hs, got_x[0], got_y[0], done_cyc);
    end
  endtask

  task automatic test_hit_flash();
    int fl_on;
`ifdef HIT_FLASH_EN
    fl_on = 1;
`else
    fl_on = 0;
`endif
    for (int f = 0; f < 4; f++) begin
      set_basic();
      if (f == 0) begin
        @(posedge clk);
        #1;
        hit = 1'b1;
        @(posedge clk);
        #1;
        hit = 1'b0;
      end
      s_fl = (f == 0 || f == 2) ? fl_on : 0;
      pulse_start(f == 1);
      collect(0, -1, -1);
      n_chk++;
      if (n_hs !== 300) begin
        n_fail++;
        $display("FAIL flash_count frame %0d: got %0d tiles, want 300", f, n_hs);
      end
      for (int i = 0; i < n_hs && i < 300; i++) begin
        n_chk++;
        if (got_c[i] !== exp_code(i % 20, i / 20)) begin
          n_fail++;
          $display("FAIL flash_tile frame %0d tile %0d: got %0d, want %0d",
                   f, i, got_c[i], exp_code(i % 20, i / 20));
        end
      end
    end
  endtask

  initial begin
    for (int e = 0; e < 3; e++) begin
      ex[e] = '0; ey[e] = '0; ea[e] = 1'b0;
    end
    tif.tile_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_priority();
    test_stall();
    test_overrun();
    test_reset_mid();
    test_hit_flash();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
